// File: rtl/alsu_pkg.sv
// Shared definitions for the multi-cycle ALSU: opcode values, FSM states and
// flag-register bit positions.
package alsu_pkg;

    localparam int ALSU_ADD = 0;
    localparam int ALSU_SUB = 1;
    localparam int ALSU_ADC = 2;
    localparam int ALSU_SBB = 3;
    localparam int ALSU_INC = 4;
    localparam int ALSU_DEC = 5;
    localparam int ALSU_AND = 6;
    localparam int ALSU_OR  = 7;
    localparam int ALSU_XOR = 8;
    localparam int ALSU_NOT = 9;
    localparam int ALSU_SHL = 10;
    localparam int ALSU_SHR = 11;
    localparam int ALSU_SAR = 12;
    localparam int ALSU_MUL = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alsu_state_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alsu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// the first bit consumed on the start edge, DATAWIDTH cycles in total.
module alsu_shift_add_mul #(
    parameter int DATAWIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [DATAWIDTH-1:0]     a_i,
    input  logic [DATAWIDTH-1:0]     b_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [2*DATAWIDTH-1:0]   product_o
);

    localparam int CNTBITS = $clog2(DATAWIDTH);

    logic [2*DATAWIDTH-1:0] acc_q, acc_d;
    logic [2*DATAWIDTH-1:0] mcand_q, mcand_d;
    logic [DATAWIDTH-1:0]   mplier_q, mplier_d;
    logic [CNTBITS-1:0]     cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic [2*DATAWIDTH-1:0] partial;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        partial  = mplier_q[0] ? mcand_q : '0;
        if (start_i) begin
            acc_d    = b_i[0] ? {{DATAWIDTH{1'b0}}, a_i} : '0;
            mcand_d  = {{(DATAWIDTH-1){1'b0}}, a_i, 1'b0};
            mplier_d = b_i >> 1;
            cnt_d    = CNTBITS'(DATAWIDTH - 1);
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + partial;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNTBITS'(1);
            if (cnt_q == CNTBITS'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    // product_o already includes the final partial so the caller can latch it on the done edge
    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == CNTBITS'(1));
    assign product_o = acc_q + partial;

endmodule

// File: rtl/alsu_mc.sv
// Multi-cycle ALSU with valid/ready handshakes, a registered Z/N/C/V flag file,
// a 1-bit-per-cycle shifter and an iterative multiplier.
module alsu_mc
    import alsu_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int FUNCBITS  = 4,
    parameter int SHAMTBITS = $clog2(DATAWIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] A,
    input  logic [DATAWIDTH-1:0] B,
    input  logic [FUNCBITS-1:0]  FUNC,
    input  logic [SHAMTBITS-1:0] SHAMT,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] R,
    output logic                 out_err,
    output logic                 Z,
    output logic                 N,
    output logic                 C,
    output logic                 V
);

    localparam int W = DATAWIDTH;

    alsu_state_e          state_q, state_d;
    logic [W-1:0]         result_q, result_d, work_q, work_d;
    logic [3:0]           flags_q, flags_d;
    logic                 err_q, err_d;
    logic [FUNCBITS-1:0]  func_q, func_d;
    logic [SHAMTBITS-1:0] cnt_q, cnt_d;

    logic                 accept, mulStart, mulBusy, mulDone;
    logic [2*W-1:0]       mulProduct;
    logic [W-1:0]         opB, shiftSrc, shiftVal, finR;
    logic [W:0]           sum;
    logic [FUNCBITS-1:0]  shiftOp;
    logic                 cin, overflow, shiftOut, finish, finErr, finC, finV;

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign mulStart = accept && (FUNC == FUNCBITS'(ALSU_MUL));

    alsu_shift_add_mul #(.DATAWIDTH(W)) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mulStart),
        .a_i       (A),
        .b_i       (B),
        .busy_o    (mulBusy),
        .done_o    (mulDone),
        .product_o (mulProduct)
    );

    // Subtracting forms use A + ~B + cin, so C=1 means no borrow
    always_comb begin
        opB = B;
        cin = 1'b0;
        case (FUNC)
            FUNCBITS'(ALSU_SUB): begin opB = ~B; cin = 1'b1; end
            FUNCBITS'(ALSU_ADC): cin = flags_q[FLAG_C];
            FUNCBITS'(ALSU_SBB): begin opB = ~B; cin = flags_q[FLAG_C]; end
            FUNCBITS'(ALSU_INC): begin opB = '0; cin = 1'b1; end
            FUNCBITS'(ALSU_DEC): opB = '1;
            default: ;
        endcase
        sum      = {1'b0, A} + {1'b0, opB} + {{W{1'b0}}, cin};
        overflow = (A[W-1] == opB[W-1]) && (sum[W-1] != A[W-1]);
    end

    always_comb begin
        shiftSrc = (state_q == ST_BUSY) ? work_q : A;
        shiftOp  = (state_q == ST_BUSY) ? func_q : FUNC;
        shiftVal = shiftSrc << 1;
        shiftOut = shiftSrc[W-1];
        if (shiftOp == FUNCBITS'(ALSU_SHR)) begin
            shiftVal = shiftSrc >> 1;
            shiftOut = shiftSrc[0];
        end else if (shiftOp == FUNCBITS'(ALSU_SAR)) begin
            shiftVal = {shiftSrc[W-1], shiftSrc[W-1:1]};
            shiftOut = shiftSrc[0];
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
        func_d   = func_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        finish   = 1'b0;
        finErr   = 1'b0;
        finR     = '0;
        finC     = 1'b0;
        finV     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_DONE) && out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    func_d = FUNC;
                    case (FUNC)
                        FUNCBITS'(ALSU_ADD), FUNCBITS'(ALSU_SUB), FUNCBITS'(ALSU_ADC),
                        FUNCBITS'(ALSU_SBB), FUNCBITS'(ALSU_INC), FUNCBITS'(ALSU_DEC): begin
                            finish = 1'b1;
                            finR   = sum[W-1:0];
                            finC   = sum[W];
                            finV   = overflow;
                        end
                        FUNCBITS'(ALSU_AND): begin finish = 1'b1; finR = A & B; end
                        FUNCBITS'(ALSU_OR):  begin finish = 1'b1; finR = A | B; end
                        FUNCBITS'(ALSU_XOR): begin finish = 1'b1; finR = A ^ B; end
                        FUNCBITS'(ALSU_NOT): begin finish = 1'b1; finR = ~A; end
                        FUNCBITS'(ALSU_SHL), FUNCBITS'(ALSU_SHR), FUNCBITS'(ALSU_SAR): begin
                            if (SHAMT == '0) begin
                                finish = 1'b1;
                                finR   = A;
                            end else if (SHAMT == SHAMTBITS'(1)) begin
                                finish = 1'b1;
                                finR   = shiftVal;
                                finC   = shiftOut;
                            end else begin
                                work_d  = shiftVal;
                                cnt_d   = SHAMT - SHAMTBITS'(1);
                                state_d = ST_BUSY;
                            end
                        end
                        FUNCBITS'(ALSU_MUL): state_d = ST_BUSY;
                        default: begin finish = 1'b1; finErr = 1'b1; end
                    endcase
                end
            end
            ST_BUSY: begin
                if (func_q == FUNCBITS'(ALSU_MUL)) begin
                    if (mulBusy && mulDone) begin
                        finish = 1'b1;
                        finR   = mulProduct[W-1:0];
                        finC   = |mulProduct[2*W-1:W];
                    end
                end else if (cnt_q == SHAMTBITS'(1)) begin
                    finish = 1'b1;
                    finR   = shiftVal;
                    finC   = shiftOut;
                end else begin
                    work_d = shiftVal;
                    cnt_d  = cnt_q - SHAMTBITS'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Undefined opcodes report an error but leave the flag file untouched
        if (finish) begin
            state_d = ST_DONE;
            err_d   = finErr;
            if (finErr) begin
                result_d = '0;
            end else begin
                result_d        = finR;
                flags_d[FLAG_Z] = (finR == '0);
                flags_d[FLAG_N] = finR[W-1];
                flags_d[FLAG_C] = finC;
                flags_d[FLAG_V] = finV;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            func_q   <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            func_q   <= func_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign R         = result_q;
    assign out_err   = err_q;
    assign Z         = flags_q[FLAG_Z];
    assign N         = flags_q[FLAG_N];
    assign C         = flags_q[FLAG_C];
    assign V         = flags_q[FLAG_V];

endmodule

// File: tb/tb_alsu_mc.sv
// Scoreboard bench for alsu_mc: directed ops push hand-computed results,
// a negedge monitor pops and compares whenever a result is presented.
module tb_alsu_mc;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_err, Z, N, C, V;
    logic [15:0] A, B, R;
    logic [3:0]  FUNC, SHAMT;

    typedef struct {
        string       name;
        logic [15:0] r;
        logic        err;
        logic [3:0]  flags;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    bit   seenValid = 1'b0;

    alsu_mc #(.DATAWIDTH(16), .FUNCBITS(4), .SHAMTBITS(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .FUNC(FUNC), .SHAMT(SHAMT),
        .out_valid(out_valid), .out_ready(out_ready), .R(R), .out_err(out_err),
        .Z(Z), .N(N), .C(C), .V(V)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string nm, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", nm, actual, expected);
        end
    endtask

    // Drives one op, holding in_valid until accepted; the expected result goes to the scoreboard
    task automatic applyStimulus(input string nm, input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] f, input logic [3:0] sh, input logic [15:0] r,
                                 input logic err, input logic [3:0] fl, input int lat);
        exp_t e;
        bit   ok = 1'b0;
        @(negedge clk);
        A = a; B = b; FUNC = f; SHAMT = sh; in_valid = 1'b1;
        for (int w = 0; w < 100; w++) begin
            #2;
            if (in_ready) begin
                e.name = nm; e.r = r; e.err = err; e.flags = fl; e.lat = lat; e.acc = cycle + 1;
                sb.push_back(e);
                ok = 1'b1;
                @(posedge clk);
                break;
            end
            @(negedge clk);
        end
        #1 in_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("[TB] FAIL %s_accept: got in_ready=0 for 100 cycles expected acceptance", nm);
        end
    endtask

    task automatic drainWait();
        for (int w = 0; w < 300 && sb.size() != 0; w++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d results outstanding expected 0", sb.size());
        end
    endtask

    initial begin
        exp_t head;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                sb.delete();
                seenValid = 1'b0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL spurious_out_valid: got out_valid=1 expected 0");
                end else begin
                    head = sb[0];
                    if (!seenValid) begin
                        checkOutput({head.name, "_latency"}, 32'(cycle - head.acc + 1), 32'(head.lat));
                        seenValid = 1'b1;
                    end
                    checkOutput({head.name, "_R"}, 32'(R), 32'(head.r));
                    checkOutput({head.name, "_err"}, 32'(out_err), 32'(head.err));
                    checkOutput({head.name, "_ZNCV"}, 32'({Z, N, C, V}), 32'(head.flags));
                    if (!out_ready) begin
                        checkOutput({head.name, "_in_ready_held"}, 32'(in_ready), 32'd0);
                    end else begin
                        void'(sb.pop_front());
                        seenValid = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; FUNC = '0; SHAMT = '0;
        repeat (2) @(negedge clk);
        #2;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_R", 32'(R), 32'd0);
        checkOutput("reset_ZNCV", 32'({Z, N, C, V}), 32'd0);
        checkOutput("reset_err", 32'(out_err), 32'd0);
        rst = 1'b0;

        //            name          A        B        F   SH  R        err   ZNCV     lat
        applyStimulus("ADD",        16'hFFFF, 16'h0001, 0,  0, 16'h0000, 1'b0, 4'b1010, 1);
        applyStimulus("ADC",        16'h0000, 16'h0000, 2,  0, 16'h0001, 1'b0, 4'b0000, 1);
        applyStimulus("SUB",        16'h8000, 16'h0001, 1,  0, 16'h7FFF, 1'b0, 4'b0011, 1);
        applyStimulus("DEC",        16'h0000, 16'h0000, 5,  0, 16'hFFFF, 1'b0, 4'b0100, 1);
        applyStimulus("SHL4",       16'h1001, 16'h0000, 10, 4, 16'h0010, 1'b0, 4'b0010, 4);
        applyStimulus("SAR3",       16'h8000, 16'h0000, 12, 3, 16'hF000, 1'b0, 4'b0100, 3);
        applyStimulus("UNDEF_F",    16'h1234, 16'h5678, 15, 0, 16'h0000, 1'b1, 4'b0100, 1);
        applyStimulus("SBB",        16'h0005, 16'h0003, 3,  0, 16'h0001, 1'b0, 4'b0010, 1);
        applyStimulus("INC",        16'h7FFF, 16'h0000, 4,  0, 16'h8000, 1'b0, 4'b0101, 1);
        applyStimulus("AND",        16'hF0F0, 16'h3C3C, 6,  0, 16'h3030, 1'b0, 4'b0000, 1);
        applyStimulus("OR",         16'h0F00, 16'h00F0, 7,  0, 16'h0FF0, 1'b0, 4'b0000, 1);
        applyStimulus("XOR",        16'hFFFF, 16'hFFFF, 8,  0, 16'h0000, 1'b0, 4'b1000, 1);
        applyStimulus("SHR1",       16'h8001, 16'h0000, 11, 1, 16'h4000, 1'b0, 4'b0010, 1);
        applyStimulus("SHL0",       16'h1234, 16'h0000, 10, 0, 16'h1234, 1'b0, 4'b0000, 1);
        applyStimulus("SHR15",      16'h0001, 16'h0000, 11, 15, 16'h0000, 1'b0, 4'b1000, 15);
        applyStimulus("MUL_ovf",    16'h0100, 16'h0100, 13, 0, 16'h0000, 1'b0, 4'b1010, 16);
        applyStimulus("MUL_small",  16'h00FF, 16'h0003, 13, 0, 16'h02FD, 1'b0, 4'b0000, 16);
        applyStimulus("UNDEF_E",    16'hAAAA, 16'h5555, 14, 0, 16'h0000, 1'b1, 4'b0000, 1);
        drainWait();

        // Result held for several cycles, then handed off in the same edge the next op is accepted
        out_ready = 1'b0;
        fork
            begin
                repeat (7) @(negedge clk);
                out_ready = 1'b1;
                #1 checkOutput("handoff_in_ready", 32'(in_ready), 32'd1);
            end
        join_none
        applyStimulus("SUB_bp",     16'h0003, 16'h0005, 1,  0, 16'hFFFE, 1'b0, 4'b0100, 1);
        applyStimulus("ADD_handoff",16'h0001, 16'h0001, 0,  0, 16'h0002, 1'b0, 4'b0000, 1);
        applyStimulus("NOT",        16'h00FF, 16'h0000, 9,  0, 16'hFF00, 1'b0, 4'b0100, 1);
        applyStimulus("MUL_abort",  16'h1234, 16'h0002, 13, 0, 16'h2468, 1'b0, 4'b0000, 16);

        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        checkOutput("midmul_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midmul_rst_R", 32'(R), 32'd0);
        checkOutput("midmul_rst_ZNCV", 32'({Z, N, C, V}), 32'd0);
        checkOutput("midmul_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        applyStimulus("UNDEF_after_rst", 16'hFFFF, 16'hFFFF, 15, 0, 16'h0000, 1'b1, 4'b0000, 1);
        drainWait();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
